// File: rtl/game_supervisor.sv
// Game-flow controller: frame-to-tick divider, run/pause/respawn/over/won FSM,
// lives/score/level. Optional macro SIM_FAST_FRAME_EN replaces i_frame with an
// internal 21-cycle frame pulse.
// Ports: clk, rst, i_restart, i_start, i_pause, i_frame, i_apple_ready,
// i_tick_done, i_failure, i_success, i_eat -> o_tick, o_respawn, o_state,
// o_lives, o_score, o_level, o_failure, o_success.
module game_supervisor #(
  parameter int LIVES            = 3,
  parameter int SCORE_W          = 8,
  parameter int WIN_SCORE        = 200,
  parameter int LEVELS           = 4,
  parameter int APPLES_PER_LEVEL = 8,
  parameter int BASE_DIV         = 8,
  parameter int DIV_STEP         = 1,
  parameter int RESPAWN_FRAMES   = 30,
  localparam int LVL_W           = $clog2(LEVELS) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_restart,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_frame,
  input  logic               i_apple_ready,
  input  logic               i_tick_done,
  input  logic               i_failure,
  input  logic               i_success,
  input  logic               i_eat,
  output logic               o_tick,
  output logic               o_respawn,
  output logic [2:0]         o_state,
  output logic [3:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [LVL_W-1:0]   o_level,
  output logic               o_failure,
  output logic               o_success
);

  localparam int EW = (APPLES_PER_LEVEL > 1) ?
                      $clog2(APPLES_PER_LEVEL) : 1;

  localparam logic [3:0]         LIVES_V   = 4'(LIVES);
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(LEVELS - 1);
  localparam logic [EW-1:0]      EAT_LAST  = EW'(APPLES_PER_LEVEL - 1);
  localparam logic [7:0]         RF_LAST   = 8'(RESPAWN_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_WAIT   = 3'd2,
    S_PAUSED = 3'd3,
    S_DYING  = 3'd4,
    S_OVER   = 3'd5,
    S_WON    = 3'd6
  } state_t;

  state_t               state, state_n;
  logic [7:0]           fcnt, fcnt_n;
  logic [3:0]           lives, lives_n;
  logic [SCORE_W-1:0]   score, score_n;
  logic [LVL_W-1:0]     level, level_n;
  logic [EW-1:0]        ecnt, ecnt_n;
  logic                 tick_q, tick_n;
  logic                 resp_q, resp_n;
  logic                 pause_q;
  logic                 frame;
  logic                 p_rise;
  logic                 live;
  logic                 active;
  logic                 win;
  int                   div_i;
  logic [7:0]           div;

`ifdef SIM_FAST_FRAME_EN
  logic [4:0] ff_cnt;
  wire        unused_frame = i_frame;

  // Free-running; only rst clears it so restarts keep the frame cadence.
  always_ff @(posedge clk) begin
    if (rst)                 ff_cnt <= '0;
    else if (ff_cnt == 5'd20) ff_cnt <= '0;
    else                     ff_cnt <= ff_cnt + 5'd1;
  end

  assign frame = (ff_cnt == 5'd20);
`else
  assign frame = i_frame;
`endif

  assign p_rise = i_pause & ~pause_q;

  // Signed arithmetic so a large level never wraps the divisor.
  always_comb begin
    div_i = BASE_DIV - int'(level) * DIV_STEP;
    div   = (div_i < 1) ? 8'd1 : 8'(div_i);
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      state   <= S_IDLE;
      fcnt    <= '0;
      lives   <= LIVES_V;
      score   <= '0;
      level   <= '0;
      ecnt    <= '0;
      tick_q  <= 1'b0;
      resp_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state   <= state_n;
      fcnt    <= fcnt_n;
      lives   <= lives_n;
      score   <= score_n;
      level   <= level_n;
      ecnt    <= ecnt_n;
      tick_q  <= tick_n;
      resp_q  <= resp_n;
      pause_q <= i_pause;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    lives_n = lives;
    score_n = score;
    level_n = level;
    ecnt_n  = ecnt;
    tick_n  = 1'b0;
    resp_n  = 1'b0;

    live   = (state != S_OVER) && (state != S_WON);
    active = (state == S_RUN) || (state == S_WAIT) ||
             (state == S_PAUSED);

    // Eats are scored before failure/win so a fatal eat still counts.
    if (live && i_eat) begin
      if (score != SCORE_MAX)
        score_n = score + SCORE_W'(1);
      if (ecnt == EAT_LAST) begin
        ecnt_n = '0;
        if (level != LVL_MAX)
          level_n = level + LVL_W'(1);
      end else begin
        ecnt_n = ecnt + EW'(1);
      end
    end

    win = live && (i_success ||
          (score_n == WIN_V && score != WIN_V));

    if (active && i_failure) begin
      lives_n = lives - 4'd1;
      if (lives == 4'd1) begin
        state_n = S_OVER;
      end else begin
        state_n = S_DYING;
        resp_n  = 1'b1;
        fcnt_n  = '0;
      end
    end else if (win) begin
      state_n = S_WON;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start && i_apple_ready) begin
            state_n = S_RUN;
            fcnt_n  = '0;
          end
        end
        S_RUN: begin
          if (p_rise) begin
            state_n = S_PAUSED;
          end else if (frame) begin
            // >= so a divisor shrink mid-count still fires next frame.
            if (fcnt >= div - 8'd1) begin
              fcnt_n = '0;
              if (i_apple_ready) begin
                tick_n  = 1'b1;
                state_n = S_WAIT;
              end
            end else begin
              fcnt_n = fcnt + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (frame && fcnt != 8'hFF)
            fcnt_n = fcnt + 8'd1;
          if (i_tick_done)
            state_n = S_RUN;
        end
        S_PAUSED: begin
          if (p_rise)
            state_n = S_RUN;
        end
        S_DYING: begin
          if (frame) begin
            if (fcnt >= RF_LAST) begin
              fcnt_n  = '0;
              state_n = S_IDLE;
            end else begin
              fcnt_n = fcnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tick    = tick_q;
  assign o_respawn = resp_q;
  assign o_state   = state;
  assign o_lives   = lives;
  assign o_score   = score;
  assign o_level   = level;
  assign o_failure = (state == S_OVER);
  assign o_success = (state == S_WON);

endmodule

// File: tb/tb_game_supervisor.sv
// Directed bench for game_supervisor with default parameters.
// Tasks per scenario; inputs change and outputs are read 1ns after posedge.
module tb_game_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_restart = 1'b0;
  logic       i_start = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_frame = 1'b0;
  logic       i_apple_ready = 1'b0;
  logic       i_tick_done = 1'b0;
  logic       i_failure = 1'b0;
  logic       i_success = 1'b0;
  logic       i_eat = 1'b0;
  logic       o_tick;
  logic       o_respawn;
  logic [2:0] o_state;
  logic [3:0] o_lives;
  logic [7:0] o_score;
  logic [2:0] o_level;
  logic       o_failure;
  logic       o_success;

  int checks = 0;
  int errors = 0;

  game_supervisor dut (
    .clk(clk), .rst(rst), .i_restart(i_restart),
    .i_start(i_start), .i_pause(i_pause), .i_frame(i_frame),
    .i_apple_ready(i_apple_ready), .i_tick_done(i_tick_done),
    .i_failure(i_failure), .i_success(i_success), .i_eat(i_eat),
    .o_tick(o_tick), .o_respawn(o_respawn), .o_state(o_state),
    .o_lives(o_lives), .o_score(o_score), .o_level(o_level),
    .o_failure(o_failure), .o_success(o_success)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      i_frame = 1'b1;
      cyc();
      i_frame = 1'b0;
      if (o_tick) ticks++;
    end
  endtask

  // Frames until o_tick; 0 if no tick within the budget.
  task automatic run_to_tick(output int n);
    int k;
    n = 0;
    for (k = 1; k <= 300; k++) begin
      i_frame = 1'b1;
      cyc();
      i_frame = 1'b0;
      if (o_tick) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic done();
    i_tick_done = 1'b1;
    cyc();
    i_tick_done = 1'b0;
  endtask

  task automatic eats(input int n);
    for (int i = 0; i < n; i++) begin
      i_eat = 1'b1;
      cyc();
    end
    i_eat = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", o_state); end
    checks++; if (o_lives !== 4'd3) begin errors++; $display("FAIL rst_lives got %0d exp 3", o_lives); end
    checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d exp 0", o_score); end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", o_level); end
    checks++; if ({o_tick, o_respawn, o_failure, o_success} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {o_tick, o_respawn, o_failure, o_success}); end
  endtask

  task automatic test_tick_rate();
    int n;
    i_start = 1'b1;
    i_apple_ready = 1'b1;
    cyc();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL start_run got %0d exp 1", o_state); end
    run_to_tick(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL first_tick frames got %0d exp 8", n); end
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL tick_wait got %0d exp 2", o_state); end
    cyc();
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL tick_single got %0d exp 0", o_tick); end
    done();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL done_run got %0d exp 1", o_state); end
    run_to_tick(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL second_tick frames got %0d exp 8", n); end
    done();
  endtask

  task automatic test_pause();
    int n;
    int t;
    frames(3, t);
    i_pause = 1'b1;
    cyc();
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL pause_enter got %0d exp 3", o_state); end
    frames(20, t);
    checks++; if (t !== 0) begin errors++; $display("FAIL pause_frozen ticks got %0d exp 0", t); end
    i_pause = 1'b0;
    cyc();
    i_pause = 1'b1;
    cyc();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL pause_resume got %0d exp 1", o_state); end
    i_pause = 1'b0;
    run_to_tick(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL pause_count_kept frames got %0d exp 5", n); end
    i_pause = 1'b1;
    cyc();
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL pause_in_wait got %0d exp 2", o_state); end
    i_pause = 1'b0;
    done();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL wait_done got %0d exp 1", o_state); end
  endtask

  task automatic test_apple_drop();
    int n;
    int t;
    i_apple_ready = 1'b0;
    frames(8, t);
    checks++; if (t !== 0) begin errors++; $display("FAIL drop_ticks got %0d exp 0", t); end
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL drop_state got %0d exp 1", o_state); end
    i_apple_ready = 1'b1;
    run_to_tick(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL drop_next frames got %0d exp 8", n); end
    done();
  endtask

  task automatic test_level();
    int n;
    eats(8);
    checks++; if (o_score !== 8'd8) begin errors++; $display("FAIL lvl_score8 got %0d exp 8", o_score); end
    checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL lvl_level1 got %0d exp 1", o_level); end
    run_to_tick(n);
    checks++; if (n !== 7) begin errors++; $display("FAIL lvl1_div frames got %0d exp 7", n); end
    done();
    eats(24);
    checks++; if (o_level !== 3'd3) begin errors++; $display("FAIL lvl_level3 got %0d exp 3", o_level); end
    run_to_tick(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL lvl3_div frames got %0d exp 5", n); end
    done();
    eats(8);
    checks++; if (o_level !== 3'd3) begin errors++; $display("FAIL lvl_sat got %0d exp 3", o_level); end
    checks++; if (o_score !== 8'd40) begin errors++; $display("FAIL lvl_score40 got %0d exp 40", o_score); end
  endtask

  task automatic test_failure();
    int t;
    i_failure = 1'b1;
    cyc();
    i_failure = 1'b0;
    checks++; if (o_respawn !== 1'b1) begin errors++; $display("FAIL fail1_respawn got %0d exp 1", o_respawn); end
    checks++; if (o_lives !== 4'd2) begin errors++; $display("FAIL fail1_lives got %0d exp 2", o_lives); end
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL fail1_state got %0d exp 4", o_state); end
    cyc();
    checks++; if (o_respawn !== 1'b0) begin errors++; $display("FAIL respawn_single got %0d exp 0", o_respawn); end
    frames(29, t);
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL dying_29 got %0d exp 4", o_state); end
    frames(1, t);
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL dying_30 got %0d exp 0", o_state); end
    cyc();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL respawn_run got %0d exp 1", o_state); end
    checks++; if (o_score !== 8'd40) begin errors++; $display("FAIL score_kept got %0d exp 40", o_score); end
    i_failure = 1'b1;
    cyc();
    i_failure = 1'b0;
    checks++; if (o_lives !== 4'd1) begin errors++; $display("FAIL fail2_lives got %0d exp 1", o_lives); end
    frames(30, t);
    cyc();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL fail2_run got %0d exp 1", o_state); end
    i_failure = 1'b1;
    cyc();
    i_failure = 1'b0;
    checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL over_state got %0d exp 5", o_state); end
    checks++; if (o_failure !== 1'b1) begin errors++; $display("FAIL over_flag got %0d exp 1", o_failure); end
    checks++; if (o_lives !== 4'd0) begin errors++; $display("FAIL over_lives got %0d exp 0", o_lives); end
    checks++; if (o_respawn !== 1'b0) begin errors++; $display("FAIL over_respawn got %0d exp 0", o_respawn); end
    eats(1);
    checks++; if (o_score !== 8'd40) begin errors++; $display("FAIL over_eat got %0d exp 40", o_score); end
  endtask

  task automatic test_restart();
    i_restart = 1'b1;
    cyc();
    i_restart = 1'b0;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rs_state got %0d exp 0", o_state); end
    checks++; if (o_lives !== 4'd3) begin errors++; $display("FAIL rs_lives got %0d exp 3", o_lives); end
    checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL rs_score got %0d exp 0", o_score); end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL rs_level got %0d exp 0", o_level); end
    checks++; if (o_failure !== 1'b0) begin errors++; $display("FAIL rs_failure got %0d exp 0", o_failure); end
  endtask

  task automatic test_fail_success();
    cyc();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL fs_run got %0d exp 1", o_state); end
    i_failure = 1'b1;
    i_success = 1'b1;
    cyc();
    i_failure = 1'b0;
    i_success = 1'b0;
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL fs_state got %0d exp 4", o_state); end
    checks++; if (o_lives !== 4'd2) begin errors++; $display("FAIL fs_lives got %0d exp 2", o_lives); end
  endtask

  task automatic test_win();
    i_restart = 1'b1;
    cyc();
    i_restart = 1'b0;
    cyc();
    eats(199);
    checks++; if (o_score !== 8'd199) begin errors++; $display("FAIL win_199 got %0d exp 199", o_score); end
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL win_pre got %0d exp 1", o_state); end
    eats(1);
    checks++; if (o_state !== 3'd6) begin errors++; $display("FAIL win_state got %0d exp 6", o_state); end
    checks++; if (o_success !== 1'b1) begin errors++; $display("FAIL win_flag got %0d exp 1", o_success); end
    checks++; if (o_score !== 8'd200) begin errors++; $display("FAIL win_score got %0d exp 200", o_score); end
    eats(1);
    i_failure = 1'b1;
    cyc();
    i_failure = 1'b0;
    checks++; if (o_score !== 8'd200) begin errors++; $display("FAIL won_eat got %0d exp 200", o_score); end
    checks++; if (o_state !== 3'd6) begin errors++; $display("FAIL won_fail got %0d exp 6", o_state); end
    checks++; if (o_lives !== 4'd3) begin errors++; $display("FAIL won_lives got %0d exp 3", o_lives); end
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_pause();
    test_apple_drop();
    test_level();
    test_failure();
    test_restart();
    test_fail_success();
    test_win();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
